// File: rtl/pulse_width_meter.sv
// pulse_width_meter
//   Measures the width, in clock cycles, of every high pulse on level_in.
//   Each completed width goes into a one-entry valid/ready result register.
//   Widths that overflow the counter are clamped and flagged. A result that
//   completes while the register is still full is lost, and drop is set.
//
// Optional feature (macro): PULSE_METER_MIN_FILTER_EN
//   When defined, completed pulses shorter than MIN_LEN are discarded
//   silently. When undefined, every pulse is reported and MIN_LEN is unused.
//
// Parameters:
//   CNT_W    width of the pulse counter and of width_out
//   MIN_LEN  minimum reportable width (filter build only)
//
// Ports:
//   clk          clock, rising edge
//   rstn         asynchronous reset, active-low
//   level_in     level stream, already synchronous to clk
//   width_out    measured width in cycles
//   width_sat    width_out is clamped; true width is at least 2^CNT_W-1
//   width_valid  result register holds an unconsumed result
//   width_ready  downstream accepts the result
//   busy         a pulse is being measured
//   drop         sticky: a completed result was lost (cleared by reset only)
module pulse_width_meter #(
  parameter int CNT_W   = 8,
  parameter int MIN_LEN = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             level_in,
  output logic [CNT_W-1:0] width_out,
  output logic             width_sat,
  output logic             width_valid,
  input  logic             width_ready,
  output logic             busy,
  output logic             drop
);

  typedef enum logic {IDLE, MEASURE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifdef PULSE_METER_MIN_FILTER_EN
  localparam logic [CNT_W-1:0] MIN_THR = CNT_W'(MIN_LEN);
`else
  // A completed pulse is always at least 1 long, so a threshold of 1 lets
  // everything through; MIN_LEN has no influence on this build.
  localparam logic [CNT_W-1:0] MIN_THR = CNT_W'((MIN_LEN >= 0) ? 1 : 1);
`endif

  state_t           state, state_nxt;
  logic             lvl_d;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             sat, sat_nxt;
  logic             done;
  logic             report;

  // Increment that holds at the counter maximum instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // Measurement FSM: next state, counter and saturation flag.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sat_nxt   = sat;
    done      = 1'b0;
    case (state)
      IDLE: begin
        // lvl_d resets high, so a level already high at reset release
        // never looks like a rising edge.
        if (level_in && !lvl_d) begin
          state_nxt = MEASURE;
          cnt_nxt   = CNT_ONE;
          sat_nxt   = 1'b0;
        end
      end
      MEASURE: begin
        if (level_in) begin
          cnt_nxt = sat_inc(cnt);
          if (cnt == CNT_MAX) sat_nxt = 1'b1;
        end else begin
          done      = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
          sat_nxt   = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign report = done && (cnt >= MIN_THR);
  assign busy   = (state == MEASURE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      lvl_d <= 1'b1;
      cnt   <= '0;
      sat   <= 1'b0;
    end else begin
      state <= state_nxt;
      lvl_d <= level_in;
      cnt   <= cnt_nxt;
      sat   <= sat_nxt;
    end
  end

  // Result register: a new result may load on the same edge the old one
  // is accepted, giving one result per pulse with no bubble.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      width_out   <= '0;
      width_sat   <= 1'b0;
      width_valid <= 1'b0;
      drop        <= 1'b0;
    end else if (report) begin
      if (!width_valid || width_ready) begin
        width_out   <= cnt;
        width_sat   <= sat;
        width_valid <= 1'b1;
      end else begin
        drop <= 1'b1;
      end
    end else if (width_valid && width_ready) begin
      width_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pulse_width_meter.sv
module tb_pulse_width_meter;

  localparam int CNT_W   = 4;
  localparam int MIN_LEN = 2;
  localparam int MAXV    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             level_in = 1'b0;
  logic             width_ready = 1'b0;
  logic [CNT_W-1:0] width_out;
  logic             width_sat;
  logic             width_valid;
  logic             busy;
  logic             drop;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, expressed in pulse terms.
  int run      = 0;   // consecutive high samples of the current pulse
  bit prev     = 1;   // previous sampled level (high after reset)
  bit ev       = 0;
  int eo       = 0;
  bit es       = 0;
  bit ed       = 0;

  pulse_width_meter #(.CNT_W(CNT_W), .MIN_LEN(MIN_LEN)) dut (
    .clk(clk), .rstn(rstn), .level_in(level_in),
    .width_out(width_out), .width_sat(width_sat), .width_valid(width_valid),
    .width_ready(width_ready), .busy(busy), .drop(drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit reportable(input int w);
`ifdef PULSE_METER_MIN_FILTER_EN
    return w >= MIN_LEN;
`else
    return w >= 1;
`endif
  endfunction

  // Effect of one rising edge with the given sampled inputs.
  task automatic model_edge(input bit lvl, input bit rdy);
    bit acc;
    bit rep;
    acc = ev && rdy;
    rep = (!lvl && run > 0) && reportable(run);
    if (rep && (!ev || rdy)) begin
      ev = 1;
      eo = (run > MAXV) ? MAXV : run;
      es = (run > MAXV);
    end else begin
      if (rep) ed = 1;
      if (acc) ev = 0;
    end
    if (lvl) begin
      if (run > 0) run++;
      else if (!prev) run = 1;
    end else begin
      run = 0;
    end
    prev = lvl;
  endtask

  task automatic compare_all();
    chk("busy", int'(busy), (run > 0) ? 1 : 0);
    chk("valid", int'(width_valid), int'(ev));
    chk("drop", int'(drop), int'(ed));
    if (ev) begin
      chk("width_out", int'(width_out), eo);
      chk("width_sat", int'(width_sat), int'(es));
    end
  endtask

  task automatic step(input bit lvl, input bit rdy);
    level_in    = lvl;
    width_ready = rdy;
    @(posedge clk);
    model_edge(lvl, rdy);
    #1;
    compare_all();
  endtask

  task automatic pulse(input int hi, input int lo, input bit rdy);
    for (int i = 0; i < hi; i++) step(1'b1, rdy);
    for (int i = 0; i < lo; i++) step(1'b0, rdy);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset(input bit lvl);
    level_in = lvl;
    #2 rstn = 1'b0;
    #1;
    chk("rst_out", int'(width_out), 0);
    chk("rst_sat", int'(width_sat), 0);
    chk("rst_valid", int'(width_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_drop", int'(drop), 0);
    run = 0; prev = 1; ev = 0; eo = 0; es = 0; ed = 0;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset(1'b0);

    // Basic pulse of 5 with ready high.
    pulse(0, 2, 1'b1);
    pulse(5, 3, 1'b1);

    // Backpressure: 3 held, 7 dropped, then drain.
    pulse(3, 2, 1'b0);
    pulse(7, 2, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);

    // Accept-and-reload on the completion edge (held 4, then 6).
    do_reset(1'b0);
    pulse(0, 1, 1'b0);
    pulse(4, 2, 1'b0);
    pulse(6, 0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);

    // Saturation: 20 cycles, and exactly the maximum and maximum+1.
    pulse(20, 2, 1'b1);
    pulse(MAXV, 2, 1'b1);
    pulse(MAXV + 1, 2, 1'b1);

    // Level high through reset release: no result.
    do_reset(1'b1);
    pulse(10, 3, 1'b1);

    // Reset in the middle of a pulse.
    pulse(6, 0, 1'b1);
    do_reset(1'b1);
    pulse(3, 3, 1'b1);
    pulse(2, 2, 1'b1);

    // Short pulses around the filter threshold, back to back.
    pulse(1, 1, 1'b1);
    pulse(2, 1, 1'b1);
    pulse(1, 1, 1'b0);
    step(1'b0, 1'b1);

    // Randomized pulses, gaps, backpressure and occasional resets.
    for (int p = 0; p < 250; p++) begin
      int hi;
      int lo;
      hi = $urandom_range(1, 20);
      lo = $urandom_range(1, 4);
      if ($urandom_range(0, 39) == 0) begin
        for (int i = 0; i < hi / 2; i++) step(1'b1, 1'($urandom_range(0, 1)));
        do_reset(1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < hi; i++) step(1'b1, ($urandom_range(0, 9) < 6));
      for (int i = 0; i < lo; i++) step(1'b0, ($urandom_range(0, 9) < 6));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
